// File: rtl/idli_nibble_ser_m_if.sv
// Word-in / nibble-out link between an instruction source and idli_nibble_ser_m.
// master drives the word handshake and stall; slave is the serializer.
interface idli_nibble_ser_m_if #(
  parameter int unsigned WORD_W = 16,
  parameter int unsigned NIB_W  = 4
);
  logic [WORD_W-1:0] i_ser_word;
  logic              i_ser_word_vld;
  logic              o_ser_word_rdy;
  logic              i_ser_stall;
  logic [NIB_W-1:0]  o_ser_nib;
  logic              o_ser_nib_vld;
  logic              o_ser_sop;
  logic              o_ser_idle;

  modport master (
    output i_ser_word, i_ser_word_vld, i_ser_stall,
    input  o_ser_word_rdy, o_ser_nib, o_ser_nib_vld, o_ser_sop, o_ser_idle
  );

  modport slave (
    input  i_ser_word, i_ser_word_vld, i_ser_stall,
    output o_ser_word_rdy, o_ser_nib, o_ser_nib_vld, o_ser_sop, o_ser_idle
  );
endinterface

// File: rtl/idli_nibble_ser_m.sv
// Nibble-serial instruction transmitter: accepts a word, streams it LS nibble first.
// Define IDLI_SER_PARITY_EN to append an even-parity beat after each word.
module idli_nibble_ser_m #(
  parameter int unsigned WORD_W = 16,
  parameter int unsigned NIB_W  = 4
) (
  input  logic               i_ser_gck,
  input  logic               i_ser_rst,
  idli_nibble_ser_m_if.slave ser
);
  localparam int unsigned BEATS = WORD_W / NIB_W;
`ifdef IDLI_SER_PARITY_EN
  localparam int unsigned TOTAL = BEATS + 1;
`else
  localparam int unsigned TOTAL = BEATS;
`endif
  localparam int unsigned CNT_W = (TOTAL > 1) ? $clog2(TOTAL) : 1;

  typedef enum logic {IDLE, SEND} state_t;

  state_t            state;
  logic [WORD_W-1:0] cur_sh;
  logic [WORD_W-1:0] pend_word;
  logic              pend_vld;
  logic [CNT_W-1:0]  cnt;
  logic [NIB_W-1:0]  nib_q;
  logic              nib_vld_q;
  logic              sop_q;
`ifdef IDLI_SER_PARITY_EN
  logic              cur_par;
`endif

  logic              accept;
  logic              last_beat;
  logic [WORD_W-1:0] load_word;
  logic [NIB_W-1:0]  next_nib;

  assign ser.o_ser_word_rdy = !pend_vld;
  assign ser.o_ser_idle     = (state == IDLE) && !pend_vld;
  assign ser.o_ser_nib      = nib_q;
  assign ser.o_ser_nib_vld  = nib_vld_q;
  assign ser.o_ser_sop      = sop_q;

  assign accept    = ser.i_ser_word_vld && !pend_vld;
  assign last_beat = (cnt == CNT_W'(TOTAL - 1));
  // Pending is always empty in IDLE, so one mux serves both load paths.
  assign load_word = pend_vld ? pend_word : ser.i_ser_word;

`ifdef IDLI_SER_PARITY_EN
  assign next_nib = (cnt == CNT_W'(BEATS - 1)) ? {{(NIB_W-1){1'b0}}, cur_par}
                                               : cur_sh[NIB_W-1:0];
`else
  assign next_nib = cur_sh[NIB_W-1:0];
`endif

  always_ff @(posedge i_ser_gck) begin
    if (i_ser_rst) begin
      state     <= IDLE;
      cur_sh    <= '0;
      pend_word <= '0;
      pend_vld  <= 1'b0;
      cnt       <= '0;
      nib_q     <= '0;
      nib_vld_q <= 1'b0;
      sop_q     <= 1'b0;
`ifdef IDLI_SER_PARITY_EN
      cur_par   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            state     <= SEND;
            cnt       <= '0;
            nib_q     <= load_word[NIB_W-1:0];
            cur_sh    <= load_word >> NIB_W;
            nib_vld_q <= 1'b1;
            sop_q     <= 1'b1;
`ifdef IDLI_SER_PARITY_EN
            cur_par   <= ^load_word;
`endif
          end
        end
        SEND: begin
          if (!ser.i_ser_stall && last_beat) begin
            // Word finished: hand off pending, take a fresh word, or go idle.
            if (pend_vld || accept) begin
              cnt       <= '0;
              nib_q     <= load_word[NIB_W-1:0];
              cur_sh    <= load_word >> NIB_W;
              nib_vld_q <= 1'b1;
              sop_q     <= 1'b1;
              pend_vld  <= 1'b0;
`ifdef IDLI_SER_PARITY_EN
              cur_par   <= ^load_word;
`endif
            end else begin
              state     <= IDLE;
              nib_vld_q <= 1'b0;
              sop_q     <= 1'b0;
            end
          end else begin
            if (!ser.i_ser_stall) begin
              cnt    <= cnt + CNT_W'(1);
              nib_q  <= next_nib;
              cur_sh <= cur_sh >> NIB_W;
              sop_q  <= 1'b0;
            end
            if (accept) begin
              pend_word <= ser.i_ser_word;
              pend_vld  <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
